// File: rtl/pipe_pkg.sv
// Shared types and default widths for the pipeline stage register.
package pipe_pkg;

  // Occupancy of the stage: number of beats held (main, then skid).
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } pipe_state_e;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_CTRL_W = 24;
  localparam int DEF_CNT_W  = 4;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear, otherwise increment unless already at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Two-entry skid-buffered pipeline stage with flush and head stall counter.
//
//   state    | meaning
//   ---------+---------------------------------------------------
//   ST_EMPTY | no beat held, Out_Ctrl reads as bubble (zero)
//   ST_ONE   | head beat in main register, skid free
//   ST_TWO   | main and skid both valid, upstream held off
//
// All outputs come straight from flops or state decode, so there is no
// combinational path from In_* to Out_* nor from Out_Ready to In_Ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CTRL_W = DEF_CTRL_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Flush,
  input  logic              In_Valid,
  output logic              In_Ready,
  input  logic [CTRL_W-1:0] In_Ctrl,
  input  logic [DATA_W-1:0] In_Data,
  output logic              Out_Valid,
  input  logic              Out_Ready,
  output logic [CTRL_W-1:0] Out_Ctrl,
  output logic [DATA_W-1:0] Out_Data,
  output logic [CNT_W-1:0]  Stall_Cnt
);

  pipe_state_e       state_q, state_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              accept;
  logic              drain;

  assign accept = In_Valid & In_Ready & ~Flush;
  assign drain  = Out_Valid & Out_Ready;

  // State and payload registers.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= ST_EMPTY;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
    end else begin
      state_q     <= state_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
    end
  end

  // Next-state: flush overrides everything, otherwise track occupancy.
  always_comb begin
    state_d = state_q;
    if (Flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (accept) state_d = ST_ONE;
        ST_ONE: begin
          if (accept && !drain)      state_d = ST_TWO;
          else if (!accept && drain) state_d = ST_EMPTY;
        end
        ST_TWO:   if (drain) state_d = ST_ONE;
        default:  state_d = ST_EMPTY;
      endcase
    end
  end

  // Payload moves: load main/skid, promote skid, bubble ctrl when emptying.
  always_comb begin
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    if (Flush) begin
      // Data is left as-is; only the control bits must read as a bubble.
      main_ctrl_d = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            main_ctrl_d = In_Ctrl;
            main_data_d = In_Data;
          end
        end
        ST_ONE: begin
          if (accept && drain) begin
            main_ctrl_d = In_Ctrl;
            main_data_d = In_Data;
          end else if (accept) begin
            skid_ctrl_d = In_Ctrl;
            skid_data_d = In_Data;
          end else if (drain) begin
            main_ctrl_d = '0;
          end
        end
        ST_TWO: begin
          if (drain) begin
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
          end
        end
        default: main_ctrl_d = '0;
      endcase
    end
  end

  // Outputs decoded from registered state and payload only.
  always_comb begin
    Out_Valid = (state_q != ST_EMPTY);
    In_Ready  = (state_q != ST_TWO);
    Out_Ctrl  = main_ctrl_q;
    Out_Data  = main_data_q;
  end

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk   (Clk),
    .rst_n (Rst_n),
    .inc   (Out_Valid & ~Out_Ready),
    .clr   (drain | Flush),
    .cnt   (Stall_Cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: beats are pushed as they are accepted
// and popped as they drain; a queue-based model predicts occupancy and stall.
module tb_pipe_stage_reg;

  localparam int DW = 32;
  localparam int CW = 8;
  localparam int NW = 4;

  typedef struct {
    logic [CW-1:0] ctrl;
    logic [DW-1:0] data;
  } beat_t;

  logic          clk_sys = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic [NW-1:0] stall_cnt;

  int     n_checks = 0;
  int     n_fail   = 0;
  beat_t  exp_q[$];
  int     stall_m  = 0;
  logic [DW-1:0] last_data = '0;
  logic   acc_flag = 1'b0;
  int     n_drained = 0;

  pipe_stage_reg #(
    .DATA_W (DW),
    .CTRL_W (CW),
    .CNT_W  (NW)
  ) dut (
    .Clk       (clk_sys),
    .Rst_n     (rst_n),
    .Flush     (flush),
    .In_Valid  (in_valid),
    .In_Ready  (in_ready),
    .In_Ctrl   (in_ctrl),
    .In_Data   (in_data),
    .Out_Valid (out_valid),
    .Out_Ready (out_ready),
    .Out_Ctrl  (out_ctrl),
    .Out_Data  (out_data),
    .Stall_Cnt (stall_cnt)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor and scoreboard, evaluated mid-cycle when everything is stable.
  always @(negedge clk_sys) begin
    if (!rst_n) begin
      exp_q.delete();
      stall_m   = 0;
      last_data = '0;
      acc_flag  = 1'b0;
    end else begin
      logic did_drain;
      logic did_acc;
      check("out_valid", out_valid, exp_q.size() != 0);
      check("in_ready", in_ready, exp_q.size() < 2);
      check("stall_cnt", stall_cnt, stall_m);
      if (exp_q.size() == 0) begin
        check("bubble_ctrl", out_ctrl, 0);
        check("held_data", out_data, last_data);
      end else begin
        last_data = exp_q[0].data;
        check("head_ctrl", out_ctrl, exp_q[0].ctrl);
        check("head_data", out_data, exp_q[0].data);
      end
      did_drain = (exp_q.size() != 0) && out_ready;
      did_acc   = in_valid && (exp_q.size() < 2) && !flush;
      acc_flag  = did_acc;
      if (flush) begin
        exp_q.delete();
        stall_m = 0;
      end else begin
        if (did_drain) begin
          void'(exp_q.pop_front());
          n_drained++;
          stall_m = 0;
        end else if (exp_q.size() != 0) begin
          stall_m = (stall_m < (1 << NW) - 1) ? stall_m + 1 : stall_m;
        end
        if (did_acc) begin
          beat_t b;
          b.ctrl = in_ctrl;
          b.data = in_data;
          exp_q.push_back(b);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk_sys);
    #1;
  endtask

  // Hold a beat on the input until the scoreboard sees it accepted.
  task automatic send(input logic [CW-1:0] c, input logic [DW-1:0] d);
    in_valid = 1'b1;
    in_ctrl  = c;
    in_data  = d;
    for (int i = 0; i < 100; i++) begin
      cyc();
      if (acc_flag) begin
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    n_checks++;
    n_fail++;
    $display("FAIL send_timeout: got no accept expected accept for data 0x%0h", d);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_data = '0; out_ready = 1'b0;
    repeat (2) cyc();
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_ctrl", out_ctrl, 0);
    check("rst_out_data", out_data, 0);
    check("rst_stall", stall_cnt, 0);
    rst_n = 1'b1;
    cyc();

    // Streaming at full rate.
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) send(8'(i + 1), 32'h11 + 32'(i));
    repeat (2) cyc();
    check("stream_drained", n_drained, 4);

    // Backpressure: A and B fill the stage, C waits for space.
    out_ready = 1'b0;
    send(8'hA1, 32'hAAAA_0001);
    send(8'hB2, 32'hBBBB_0002);
    fork
      send(8'hC3, 32'hCCCC_0003);
      begin
        repeat (3) cyc();
        out_ready = 1'b1;
      end
    join
    repeat (3) cyc();
    check("bp_drained", n_drained, 7);

    // Stall counter saturation then clear on drain.
    out_ready = 1'b0;
    send(8'h33, 32'h3333_3333);
    repeat (20) cyc();
    check("sat_value", stall_cnt, 15);
    out_ready = 1'b1;
    cyc();
    cyc();

    // Flush from TWO with a concurrent input beat.
    out_ready = 1'b0;
    send(8'h01, 32'h0101_0101);
    send(8'h02, 32'h0202_0202);
    in_valid = 1'b1; in_ctrl = 8'h5A; in_data = 32'h5A5A_5A5A; flush = 1'b1;
    cyc();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_valid", out_valid, 0);
    check("flush_ctrl", out_ctrl, 0);
    check("flush_ready", in_ready, 1);
    out_ready = 1'b1;
    repeat (3) cyc();

    // Asynchronous reset in the middle of a stalled TWO state.
    out_ready = 1'b0;
    send(8'h71, 32'h7171_7171);
    send(8'h72, 32'h7272_7272);
    repeat (2) cyc();
    check("pre_rst_stall", stall_cnt, 3);
    #1 rst_n = 1'b0;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_ready", in_ready, 1);
    check("arst_stall", stall_cnt, 0);
    check("arst_data", out_data, 0);
    check("arst_ctrl", out_ctrl, 0);
    @(posedge clk_sys);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    send(8'h99, 32'h9999_0000);
    cyc();

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_ctrl   = 8'($urandom);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 31) == 0);
      if ((i % 200) > 170) out_ready = 1'b0;
      cyc();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (5) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
